vsdcaravel_hkspi: RTL and testbench



---
 rtl/hkspi_pkg.sv | 51 +++++
 rtl/hkspi_sync_edge.sv | 36 +++
 rtl/vsdcaravel_hkspi.sv | 263 ++++++++++++++++++++++++++
 tb/tb_vsdcaravel_hkspi.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hkspi_pkg.sv
// Shared constants for the housekeeping SPI slave: register map, command fields, FSM states, reset values.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hkspi_pkg;

    // Register map
    localparam logic [7:0] HK_ADDR_STATUS     = 8'h00;
    localparam logic [7:0] HK_ADDR_MFG_HI     = 8'h01;
    localparam logic [7:0] HK_ADDR_MFG_LO     = 8'h02;
    localparam logic [7:0] HK_ADDR_PROD       = 8'h03;
    localparam logic [7:0] HK_ADDR_USER0      = 8'h04;
    localparam logic [7:0] HK_ADDR_USER1      = 8'h05;
    localparam logic [7:0] HK_ADDR_USER2      = 8'h06;
    localparam logic [7:0] HK_ADDR_USER3      = 8'h07;
    localparam logic [7:0] HK_ADDR_PLL_ENA    = 8'h08;
    localparam logic [7:0] HK_ADDR_PLL_BYPASS = 8'h09;
    localparam logic [7:0] HK_ADDR_IRQ        = 8'h0A;
    localparam logic [7:0] HK_ADDR_EXT_RESET  = 8'h0B;
    localparam logic [7:0] HK_ADDR_TRAP       = 8'h0C;
    localparam logic [7:0] HK_ADDR_TRIM0      = 8'h0D;
    localparam logic [7:0] HK_ADDR_TRIM1      = 8'h0E;
    localparam logic [7:0] HK_ADDR_TRIM2      = 8'h0F;
    localparam logic [7:0] HK_ADDR_TRIM3      = 8'h10;
    localparam logic [7:0] HK_ADDR_PLL_SEL    = 8'h11;
    localparam logic [7:0] HK_ADDR_PLL_DIV    = 8'h12;

    // Command byte fields
    localparam int CMD_WR_BIT  = 7;
    localparam int CMD_RD_BIT  = 6;
    localparam int CMD_CNT_MSB = 5;
    localparam int CMD_CNT_LSB = 3;

    // Transfer phases
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } hk_state_t;

    // Control register reset values
    localparam logic [1:0]  PLL_ENA_RST    = 2'b10;
    localparam logic        PLL_BYPASS_RST = 1'b1;
    localparam logic        IRQ_RST        = 1'b0;
    localparam logic        EXT_RESET_RST  = 1'b0;
    localparam logic [25:0] PLL_TRIM_RST   = 26'h3FF_EFFF;
    localparam logic [2:0]  PLL_SEL_RST    = 3'b010;
    localparam logic [2:0]  PLL90_SEL_RST  = 3'b010;
    localparam logic [4:0]  PLL_DIV_RST    = 5'd4;

endpackage

// File: rtl/hkspi_sync_edge.sv
// Two-flop synchronizer for an asynchronous pad input, plus a third stage for rise/fall detection.
// Latency: dout follows din after 2 clocks; rise/fall pulse for one clock in the cycle dout changes.
// Backpressure: none; free-running sampler.
module hkspi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic dly;

    // Synchronizer chain plus one delayed copy for edge detection
    always_ff @(posedge clock) begin
        if (reset) begin
            meta <= RST_VAL;
            sync <= RST_VAL;
            dly  <= RST_VAL;
        end else begin
            meta <= din;
            sync <= meta;
            dly  <= sync;
        end
    end

    assign dout = sync;
    assign rise = sync & ~dly;
    assign fall = ~sync & dly;

endmodule

// File: rtl/vsdcaravel_hkspi.sv
// Housekeeping SPI slave: CMD/ADDR/DATA byte protocol over oversampled pads into a small control register file.
// Latency: sdo and register commits occur 3 clocks after the pad SCK rise (2-flop sync + 1 register stage).
// Backpressure: none; host paces by SCK, CSB high aborts any partial byte and tri-states sdo.
module vsdcaravel_hkspi
    import hkspi_pkg::*;
#(
    parameter logic [15:0] MFG_ID  = 16'h0456,
    parameter logic [7:0]  PROD_ID = 8'h11,
    parameter logic [31:0] USER_ID = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        sck,
    input  logic        csb,
    input  logic        sdi,
    output logic        sdo,
    output logic        sdo_enb,
    input  logic        trap,
    output logic [1:0]  pll_ena,
    output logic        pll_bypass,
    output logic        irq,
    output logic        ext_reset,
    output logic [25:0] pll_trim,
    output logic [2:0]  pll_sel,
    output logic [2:0]  pll90_sel,
    output logic [4:0]  pll_div
);

    // Synchronized pad signals
    logic sck_q, sck_rise, sck_fall;
    logic csb_q, csb_rise, csb_fall;
    logic sdi_q, sdi_rise, sdi_fall;
    logic unused_edges;

    hkspi_sync_edge #(.RST_VAL(1'b0)) u_sync_sck (
        .clock (clock),
        .reset (reset),
        .din   (sck),
        .dout  (sck_q),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    hkspi_sync_edge #(.RST_VAL(1'b1)) u_sync_csb (
        .clock (clock),
        .reset (reset),
        .din   (csb),
        .dout  (csb_q),
        .rise  (csb_rise),
        .fall  (csb_fall)
    );

    hkspi_sync_edge #(.RST_VAL(1'b0)) u_sync_sdi (
        .clock (clock),
        .reset (reset),
        .din   (sdi),
        .dout  (sdi_q),
        .rise  (sdi_rise),
        .fall  (sdi_fall)
    );

    // Only the SCK rise and the levels of CSB/SDI drive the protocol
    assign unused_edges = ^{sck_q, sck_fall, csb_rise, csb_fall, sdi_rise, sdi_fall};

    hk_state_t   state;
    hk_state_t   state_nxt;
    logic [2:0]  bit_cnt;
    logic [6:0]  shift_in;
    logic [7:0]  rx_byte;
    logic        cmd_wr;
    logic        cmd_rd;
    logic [2:0]  cmd_cnt;
    logic [2:0]  data_cnt;
    logic [7:0]  addr;
    logic [7:0]  rd_addr;
    logic [7:0]  rd_data;
    logic [7:0]  out_shift;

    logic active;
    logic byte_done;
    logic cmd_op;
    logic last_byte;
    logic cmd_load;
    logic addr_load;
    logic data_done;
    logic shift_out;
    logic commit;
    logic load_out;
    logic enb_set;

    assign active    = ~csb_q;
    // The byte completes on the 8th rise, so its LSB is the live synchronized sdi
    assign rx_byte   = {shift_in, sdi_q};
    assign byte_done = active & sck_rise & (bit_cnt == 3'd7);
    assign cmd_op    = cmd_wr | cmd_rd;
    // Counted mode only; N=0 streams until CSB rises
    assign last_byte = (cmd_cnt != 3'd0) && (data_cnt == (cmd_cnt - 3'd1));

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: one phase per completed byte, CSB high always returns to IDLE
    always_comb begin
        state_nxt = state;
        if (csb_q) begin
            state_nxt = IDLE;
        end else if (byte_done) begin
            case (state)
                IDLE:    state_nxt = ADDR;
                ADDR:    state_nxt = DATA;
                DATA:    if (cmd_op && last_byte) state_nxt = DONE;
                default: state_nxt = DONE;
            endcase
        end
    end

    // FSM outputs: per-phase strobes for the datapath
    always_comb begin
        cmd_load  = 1'b0;
        addr_load = 1'b0;
        data_done = 1'b0;
        shift_out = 1'b0;
        case (state)
            IDLE: cmd_load  = byte_done;
            ADDR: addr_load = byte_done;
            DATA: begin
                data_done = byte_done & cmd_op;
                shift_out = active & sck_rise & ~byte_done & cmd_rd;
            end
            default: ;
        endcase
    end

    assign commit   = data_done & cmd_wr;
    // Next read byte is fetched at the end of ADDR and at the end of every non-final data byte
    assign load_out = cmd_rd & (addr_load | (data_done & ~last_byte));
    assign enb_set  = csb_q | (data_done & last_byte);
    assign rd_addr  = addr_load ? rx_byte : (addr + 8'd1);

    // Bit counter and input shifter; CSB high discards any partial byte
    always_ff @(posedge clock) begin
        if (reset) begin
            bit_cnt  <= 3'd0;
            shift_in <= 7'd0;
        end else if (csb_q) begin
            bit_cnt  <= 3'd0;
        end else if (sck_rise) begin
            bit_cnt  <= bit_cnt + 3'd1;
            shift_in <= {shift_in[5:0], sdi_q};
        end
    end

    // Command capture, address pointer and data byte counter
    always_ff @(posedge clock) begin
        if (reset) begin
            cmd_wr   <= 1'b0;
            cmd_rd   <= 1'b0;
            cmd_cnt  <= 3'd0;
            data_cnt <= 3'd0;
            addr     <= 8'd0;
        end else begin
            if (cmd_load) begin
                cmd_wr   <= rx_byte[CMD_WR_BIT];
                cmd_rd   <= rx_byte[CMD_RD_BIT];
                cmd_cnt  <= rx_byte[CMD_CNT_MSB:CMD_CNT_LSB];
                data_cnt <= 3'd0;
            end
            if (addr_load) begin
                addr <= rx_byte;
            end
            if (data_done) begin
                addr     <= addr + 8'd1;
                data_cnt <= data_cnt + 3'd1;
            end
        end
    end

    // Register read mux, addressed by the byte about to be shifted out
    always_comb begin
        rd_data = 8'h00;
        case (rd_addr)
            HK_ADDR_STATUS:     rd_data = 8'h00;
            HK_ADDR_MFG_HI:     rd_data = MFG_ID[15:8];
            HK_ADDR_MFG_LO:     rd_data = MFG_ID[7:0];
            HK_ADDR_PROD:       rd_data = PROD_ID;
            HK_ADDR_USER0:      rd_data = USER_ID[31:24];
            HK_ADDR_USER1:      rd_data = USER_ID[23:16];
            HK_ADDR_USER2:      rd_data = USER_ID[15:8];
            HK_ADDR_USER3:      rd_data = USER_ID[7:0];
            HK_ADDR_PLL_ENA:    rd_data = {6'd0, pll_ena};
            HK_ADDR_PLL_BYPASS: rd_data = {7'd0, pll_bypass};
            HK_ADDR_IRQ:        rd_data = {7'd0, irq};
            HK_ADDR_EXT_RESET:  rd_data = {7'd0, ext_reset};
            HK_ADDR_TRAP:       rd_data = {7'd0, trap};
            HK_ADDR_TRIM0:      rd_data = pll_trim[7:0];
            HK_ADDR_TRIM1:      rd_data = pll_trim[15:8];
            HK_ADDR_TRIM2:      rd_data = pll_trim[23:16];
            HK_ADDR_TRIM3:      rd_data = {6'd0, pll_trim[25:24]};
            HK_ADDR_PLL_SEL:    rd_data = {2'd0, pll90_sel, pll_sel};
            HK_ADDR_PLL_DIV:    rd_data = {3'd0, pll_div};
            default:            rd_data = 8'h00;
        endcase
    end

    // Output shifter and pad enable; sdo is always the shifter MSB
    always_ff @(posedge clock) begin
        if (reset) begin
            out_shift <= 8'h00;
            sdo_enb   <= 1'b1;
        end else begin
            if (load_out) begin
                out_shift <= rd_data;
            end else if (shift_out) begin
                out_shift <= {out_shift[6:0], 1'b0};
            end
            if (enb_set) begin
                sdo_enb <= 1'b1;
            end else if (load_out) begin
                sdo_enb <= 1'b0;
            end
        end
    end

    assign sdo = out_shift[7];

    // Writable control registers; the PLL trim word is laid out low byte first from 0x0D
    always_ff @(posedge clock) begin
        if (reset) begin
            pll_ena    <= PLL_ENA_RST;
            pll_bypass <= PLL_BYPASS_RST;
            irq        <= IRQ_RST;
            ext_reset  <= EXT_RESET_RST;
            pll_trim   <= PLL_TRIM_RST;
            pll_sel    <= PLL_SEL_RST;
            pll90_sel  <= PLL90_SEL_RST;
            pll_div    <= PLL_DIV_RST;
        end else if (commit) begin
            case (addr)
                HK_ADDR_PLL_ENA:    pll_ena          <= rx_byte[1:0];
                HK_ADDR_PLL_BYPASS: pll_bypass       <= rx_byte[0];
                HK_ADDR_IRQ:        irq              <= rx_byte[0];
                HK_ADDR_EXT_RESET:  ext_reset        <= rx_byte[0];
                HK_ADDR_TRIM0:      pll_trim[7:0]    <= rx_byte;
                HK_ADDR_TRIM1:      pll_trim[15:8]   <= rx_byte;
                HK_ADDR_TRIM2:      pll_trim[23:16]  <= rx_byte;
                HK_ADDR_TRIM3:      pll_trim[25:24]  <= rx_byte[1:0];
                HK_ADDR_PLL_SEL: begin
                    pll_sel   <= rx_byte[2:0];
                    pll90_sel <= rx_byte[5:3];
                end
                HK_ADDR_PLL_DIV:    pll_div          <= rx_byte[4:0];
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vsdcaravel_hkspi.sv
// Self-checking bench for the housekeeping SPI slave: table-driven single transactions plus hand-written corner sequences.
// Latency: SPI bit period is 12 core clocks; sdo sampled just before each SCK rise.
// Backpressure: n/a.
module tb_vsdcaravel_hkspi;

    logic        clock = 1'b0;
    logic        reset;
    logic        sck;
    logic        csb;
    logic        sdi;
    logic        sdo;
    logic        sdo_enb;
    logic        trap;
    logic [1:0]  pll_ena;
    logic        pll_bypass;
    logic        irq;
    logic        ext_reset;
    logic [25:0] pll_trim;
    logic [2:0]  pll_sel;
    logic [2:0]  pll90_sel;
    logic [4:0]  pll_div;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    vsdcaravel_hkspi dut (
        .clock      (clock),
        .reset      (reset),
        .sck        (sck),
        .csb        (csb),
        .sdi        (sdi),
        .sdo        (sdo),
        .sdo_enb    (sdo_enb),
        .trap       (trap),
        .pll_ena    (pll_ena),
        .pll_bypass (pll_bypass),
        .irq        (irq),
        .ext_reset  (ext_reset),
        .pll_trim   (pll_trim),
        .pll_sel    (pll_sel),
        .pll90_sel  (pll90_sel),
        .pll_div    (pll_div)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] addr;
        logic [7:0] wdat;
        logic       trap;
        logic       is_rd;
        logic [7:0] exp;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs[NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic sb_pop(input string name, input logic [7:0] act);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty actual=%h", name, act);
        end else begin
            e = exp_q.pop_front();
            check(name, {24'd0, act}, {24'd0, e});
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clock);
    endtask

    // One SPI bit period per bit; sdo is sampled just before each rise
    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx, output logic enb);
        rx  = 8'h00;
        enb = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            sdi = tx[i];
            wait_clk(6);
            rx = {rx[6:0], sdo};
            if (i == 7) enb = sdo_enb;
            sck = 1'b1;
            wait_clk(6);
            sck = 1'b0;
        end
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int n);
        for (int i = 0; i < n; i++) begin
            sdi = tx[7-i];
            wait_clk(6);
            sck = 1'b1;
            wait_clk(6);
            sck = 1'b0;
        end
    endtask

    task automatic cs_begin();
        @(negedge clock);
        csb = 1'b0;
        wait_clk(4);
    endtask

    task automatic cs_end();
        wait_clk(4);
        csb = 1'b1;
        wait_clk(8);
    endtask

    // Read nbytes after cmd/addr, comparing each against the scoreboard
    task automatic rd_frame(input string name, input logic [7:0] cmd, input logic [7:0] addr, input int nbytes);
        logic [7:0] rx;
        logic       enb;
        cs_begin();
        spi_byte(cmd, rx, enb);
        spi_byte(addr, rx, enb);
        for (int k = 0; k < nbytes; k++) begin
            spi_byte(8'h00, rx, enb);
            sb_pop($sformatf("%s_b%0d", name, k), rx);
        end
        cs_end();
    endtask

    task automatic wr_frame(input logic [7:0] cmd, input logic [7:0] addr, input logic [7:0] dat);
        logic [7:0] rx;
        logic       enb;
        cs_begin();
        spi_byte(cmd, rx, enb);
        spi_byte(addr, rx, enb);
        spi_byte(dat, rx, enb);
        cs_end();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rx;
        logic       enb;
        logic [7:0] stream_exp[19];

        vecs[0]  = '{8'h48, 8'h03, 8'h00, 1'b0, 1'b1, 8'h11};
        vecs[1]  = '{8'h48, 8'h01, 8'h00, 1'b0, 1'b1, 8'h04};
        vecs[2]  = '{8'h48, 8'h0C, 8'h00, 1'b1, 1'b1, 8'h01};
        vecs[3]  = '{8'h48, 8'h0C, 8'h00, 1'b0, 1'b1, 8'h00};
        vecs[4]  = '{8'h88, 8'h0A, 8'h01, 1'b0, 1'b0, 8'h00};
        vecs[5]  = '{8'h48, 8'h0A, 8'h00, 1'b0, 1'b1, 8'h01};
        vecs[6]  = '{8'h80, 8'h03, 8'h55, 1'b0, 1'b0, 8'h00};
        vecs[7]  = '{8'h80, 8'hFF, 8'h55, 1'b0, 1'b0, 8'h00};
        vecs[8]  = '{8'h48, 8'h03, 8'h00, 1'b0, 1'b1, 8'h11};
        vecs[9]  = '{8'hC8, 8'h0A, 8'h00, 1'b0, 1'b1, 8'h01};
        vecs[10] = '{8'h48, 8'h0A, 8'h00, 1'b0, 1'b1, 8'h00};
        vecs[11] = '{8'h88, 8'h08, 8'hFF, 1'b0, 1'b0, 8'h00};
        vecs[12] = '{8'h48, 8'h08, 8'h00, 1'b0, 1'b1, 8'h03};

        stream_exp = '{8'h00, 8'h04, 8'h56, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00,
                       8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hEF, 8'hFF,
                       8'h03, 8'h12, 8'h04};

        reset = 1'b1;
        sck   = 1'b0;
        csb   = 1'b1;
        sdi   = 1'b0;
        trap  = 1'b0;
        wait_clk(5);
        reset = 1'b0;
        wait_clk(3);

        // Reset state
        check("rst_sdo",        {31'd0, sdo},        32'd0);
        check("rst_sdo_enb",    {31'd0, sdo_enb},    32'd1);
        check("rst_pll_ena",    {30'd0, pll_ena},    32'd2);
        check("rst_pll_bypass", {31'd0, pll_bypass}, 32'd1);
        check("rst_irq",        {31'd0, irq},        32'd0);
        check("rst_ext_reset",  {31'd0, ext_reset},  32'd0);
        check("rst_pll_trim",   {6'd0, pll_trim},    32'h03FF_EFFF);
        check("rst_pll_sel",    {29'd0, pll_sel},    32'd2);
        check("rst_pll90_sel",  {29'd0, pll90_sel},  32'd2);
        check("rst_pll_div",    {27'd0, pll_div},    32'd4);

        // Streaming read of product ID, then pad enable must release with CSB
        cs_begin();
        spi_byte(8'h40, rx, enb);
        spi_byte(8'h03, rx, enb);
        exp_q.push_back(8'h11);
        spi_byte(8'h00, rx, enb);
        sb_pop("prod_id", rx);
        check("prod_enb_active", {31'd0, enb}, 32'd0);
        cs_end();
        check("prod_enb_release", {31'd0, sdo_enb}, 32'd1);

        // Full register map stream from reset values
        for (int k = 0; k < 19; k++) exp_q.push_back(stream_exp[k]);
        rd_frame("stream", 8'h40, 8'h00, 19);

        // Table of single-byte transactions
        for (int v = 0; v < NVEC; v++) begin
            trap = vecs[v].trap;
            cs_begin();
            spi_byte(vecs[v].cmd, rx, enb);
            spi_byte(vecs[v].addr, rx, enb);
            if (vecs[v].is_rd) exp_q.push_back(vecs[v].exp);
            spi_byte(vecs[v].wdat, rx, enb);
            if (vecs[v].is_rd) begin
                sb_pop($sformatf("vec%0d", v), rx);
                check($sformatf("vec%0d_enb", v), {31'd0, enb}, 32'd0);
            end
            cs_end();
        end
        trap = 1'b0;
        check("pll_ena_written", {30'd0, pll_ena}, 32'd3);

        // ext_reset set then cleared, then read back
        wr_frame(8'h80, 8'h0B, 8'h01);
        check("ext_reset_set", {31'd0, ext_reset}, 32'd1);
        wr_frame(8'h80, 8'h0B, 8'h00);
        check("ext_reset_clr", {31'd0, ext_reset}, 32'd0);
        exp_q.push_back(8'h00);
        rd_frame("ext_reset_rd", 8'h48, 8'h0B, 1);

        // Counted write of one byte; the extra byte must be ignored and sdo stays off
        cs_begin();
        spi_byte(8'h88, rx, enb);
        spi_byte(8'h12, rx, enb);
        spi_byte(8'h1F, rx, enb);
        spi_byte(8'hAA, rx, enb);
        check("cnt_wr_enb", {31'd0, sdo_enb}, 32'd1);
        cs_end();
        check("cnt_wr_pll_div", {27'd0, pll_div}, 32'h1F);
        check("cnt_wr_pll_sel", {29'd0, pll_sel}, 32'd2);
        check("cnt_wr_pll90_sel", {29'd0, pll90_sel}, 32'd2);

        // Counted read of two bytes, then DONE must tri-state sdo before CSB rises
        cs_begin();
        spi_byte(8'h50, rx, enb);
        spi_byte(8'h12, rx, enb);
        exp_q.push_back(8'h1F);
        exp_q.push_back(8'h00);
        spi_byte(8'h00, rx, enb);
        sb_pop("cnt_rd_12", rx);
        spi_byte(8'h00, rx, enb);
        sb_pop("cnt_rd_13", rx);
        spi_byte(8'h00, rx, enb);
        check("cnt_rd_done_enb", {31'd0, sdo_enb}, 32'd1);
        cs_end();

        // Address wrap on a stream read from 0xFF
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h04);
        rd_frame("wrap", 8'h40, 8'hFF, 3);

        // CSB rising mid-byte must discard a write to pll_bypass
        cs_begin();
        spi_byte(8'h80, rx, enb);
        spi_byte(8'h09, rx, enb);
        spi_bits(8'h00, 4);
        cs_end();
        check("abort_pll_bypass", {31'd0, pll_bypass}, 32'd1);
        exp_q.push_back(8'h01);
        rd_frame("abort_rd", 8'h48, 8'h09, 1);

        // Reset during a stream read restores trim and releases sdo
        wr_frame(8'h88, 8'h0D, 8'h00);
        check("trim_written", {6'd0, pll_trim}, 32'h03FF_EF00);
        cs_begin();
        spi_byte(8'h40, rx, enb);
        spi_byte(8'h0D, rx, enb);
        exp_q.push_back(8'h00);
        spi_byte(8'h00, rx, enb);
        sb_pop("rst_mid_b0", rx);
        spi_bits(8'hFF, 3);
        check("rst_mid_enb_before", {31'd0, sdo_enb}, 32'd0);
        reset = 1'b1;
        wait_clk(1);
        reset = 1'b0;
        check("rst_mid_enb", {31'd0, sdo_enb}, 32'd1);
        check("rst_mid_trim", {6'd0, pll_trim}, 32'h03FF_EFFF);
        cs_end();
        exp_q.push_back(8'hFF);
        rd_frame("rst_mid_rd", 8'h48, 8'h0D, 1);

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover actual=%0d required=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
